// File: rtl/zmem_responder_pkg.sv
// Shared definitions for the zephyr memory responder and the core that talks to it.
// Contents:
//   - ZMEM_ADDR_W / ZMEM_DATA_W : default RAM geometry (16 words x 8 bits).
//   - zmem_state_t              : responder FSM state encoding.
//   - OP_*                      : core opcode constants, shared so both sides agree.
package zmem_responder_pkg;

    localparam int unsigned ZMEM_ADDR_W = 4;
    localparam int unsigned ZMEM_DATA_W = 8;
    localparam int unsigned ZMEM_DEPTH  = 2 ** ZMEM_ADDR_W;

    // Code 2'b11 is unused; the FSM treats it as a return to StServe.
    typedef enum logic [1:0] {
        StServe = 2'b00,
        StLoad  = 2'b01,
        StDone  = 2'b10
    } zmem_state_t;

    // Core opcodes (upper two bits of an instruction byte). A cleared RAM reads as NOPs.
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_STR  = 2'b10;
    localparam logic [1:0] OP_ALU  = 2'b11;

endpackage

// File: rtl/zmem_responder_if.sv
// Core <-> memory request/response channel.
// Signals:
//   REQ_VALID/REQ_READY : request handshake; REQ_WE selects write (STR) vs read (fetch/LOAD)
//   REQ_ADDR/REQ_WDATA  : word address and write data
//   RSP_VALID/RSP_READY : response handshake from the responder's one-entry output buffer
//   RSP_DATA            : read data, or echoed write data for writes
// Modports: master = core side, slave = memory responder side.
interface zmem_responder_if
    import zmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = ZMEM_ADDR_W,
    parameter int unsigned DATA_W = ZMEM_DATA_W
);
    logic              REQ_VALID;
    logic              REQ_READY;
    logic              REQ_WE;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic [DATA_W-1:0] REQ_WDATA;
    logic              RSP_VALID;
    logic              RSP_READY;
    logic [DATA_W-1:0] RSP_DATA;

    modport master (
        output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, RSP_READY,
        input  REQ_READY, RSP_VALID, RSP_DATA
    );

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, RSP_READY,
        output REQ_READY, RSP_VALID, RSP_DATA
    );
endinterface

// File: rtl/zmem_responder_array.sv
// DEPTH x DATA_W storage for the responder.
// Ports:
//   CLK, RESET      : clock, asynchronous active-high reset (clears every word and the read reg)
//   we/waddr/wdata  : single synchronous write port
//   re/raddr        : read enable and address; data appears on rdata after the edge
//   rdata           : registered read data, held while re is low
module zmem_responder_array #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read register only moves on a read so a stalled response keeps its data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/zmem_responder.sv
// Memory-side responder for the zephyr core. Owns the program/data RAM, serves core fetch,
// LOAD and STR requests, and accepts a byte-stream program load that fills RAM from word 0.
// Ports:
//   CLK, RESET  : clock, asynchronous active-high reset
//   bus         : request/response channel (slave side)
//   LD_START    : level request for a program load, sampled in SERVE
//   LD_VALID/LD_READY/LD_DATA/LD_LAST : load byte stream; LD_LAST ends a short program
//   LD_DONE     : one-cycle pulse when a load completes
//   LD_COUNT    : bytes written by the current/last load
//   CORE_HOLD   : stalls the core from LOAD entry through the DONE cycle
module zmem_responder
    import zmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = ZMEM_ADDR_W,
    parameter int unsigned DATA_W = ZMEM_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    zmem_responder_if.slave   bus,
    input  logic              LD_START,
    input  logic              LD_VALID,
    output logic              LD_READY,
    input  logic [DATA_W-1:0] LD_DATA,
    input  logic              LD_LAST,
    output logic              LD_DONE,
    output logic [ADDR_W:0]   LD_COUNT,
    output logic              CORE_HOLD
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = ADDR_W'(DEPTH - 1);

    zmem_state_t       state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              rsp_valid_q;
    logic              rsp_is_rd_q;
    logic [DATA_W-1:0] rsp_wdata_q;
    logic              ld_ready_q;
    logic              hold_q;
    logic              done_q;

    logic              req_ready;
    logic              req_hs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // A pending LD_START blocks new requests so the output buffer can drain before LOAD.
    assign req_ready = (state_q == StServe) && !LD_START && (!rsp_valid_q || bus.RSP_READY);
    assign req_hs    = bus.REQ_VALID && req_ready;

    // Write-port ownership: loader in LOAD, core otherwise.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.REQ_ADDR;
        mem_wdata = bus.REQ_WDATA;
        if (state_q == StLoad) begin
            mem_we    = LD_VALID;
            mem_waddr = ptr_q;
            mem_wdata = LD_DATA;
        end else begin
            mem_we    = req_hs && bus.REQ_WE;
        end
    end

    zmem_responder_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .CLK   (CLK),
        .RESET (RESET),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (req_hs && !bus.REQ_WE),
        .raddr (bus.REQ_ADDR),
        .rdata (mem_rdata)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= StServe;
            ptr_q       <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_is_rd_q <= 1'b0;
            rsp_wdata_q <= '0;
            ld_ready_q  <= 1'b0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                StServe: begin
                    if (req_hs) begin
                        rsp_valid_q <= 1'b1;
                        rsp_is_rd_q <= !bus.REQ_WE;
                        rsp_wdata_q <= bus.REQ_WDATA;
                    end else if (bus.RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                    end
                    if (LD_START && !rsp_valid_q) begin
                        state_q    <= StLoad;
                        ptr_q      <= '0;
                        count_q    <= '0;
                        ld_ready_q <= 1'b1;
                        hold_q     <= 1'b1;
                    end
                end
                StLoad: begin
                    if (LD_VALID) begin
                        ptr_q   <= ptr_q + 1'b1;
                        count_q <= count_q + 1'b1;
                        if (LD_LAST || count_q == LAST_CNT) begin
                            state_q    <= StDone;
                            ld_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StServe;
                    done_q  <= 1'b0;
                    hold_q  <= 1'b0;
                end
                default: begin
                    state_q     <= StServe;
                    rsp_valid_q <= 1'b0;
                    ld_ready_q  <= 1'b0;
                    hold_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.REQ_READY = req_ready;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_DATA  = rsp_is_rd_q ? mem_rdata : rsp_wdata_q;
    assign LD_READY      = ld_ready_q;
    assign LD_DONE       = done_q;
    assign LD_COUNT      = count_q;
    assign CORE_HOLD     = hold_q;

endmodule

// File: tb/tb_zmem_responder.sv
// Directed self-checking bench for zmem_responder: reset state, read/write, backpressure,
// full and short program loads, and reset during a load.
module tb_zmem_responder;
    import zmem_responder_pkg::*;

    logic       CLK;
    logic       RESET;
    logic       LD_START;
    logic       LD_VALID;
    logic       LD_READY;
    logic [7:0] LD_DATA;
    logic       LD_LAST;
    logic       LD_DONE;
    logic [4:0] LD_COUNT;
    logic       CORE_HOLD;

    int n_checks = 0;
    int n_fail   = 0;

    zmem_responder_if bus ();

    zmem_responder dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .bus       (bus),
        .LD_START  (LD_START),
        .LD_VALID  (LD_VALID),
        .LD_READY  (LD_READY),
        .LD_DATA   (LD_DATA),
        .LD_LAST   (LD_LAST),
        .LD_DONE   (LD_DONE),
        .LD_COUNT  (LD_COUNT),
        .CORE_HOLD (CORE_HOLD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic we, input logic [3:0] a,
                             input logic [7:0] d);
        bus.REQ_VALID = v;
        bus.REQ_WE    = we;
        bus.REQ_ADDR  = a;
        bus.REQ_WDATA = d;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        drive_req(1'b0, 1'b0, 4'd0, 8'h00);
        bus.RSP_READY = 1'b1;
        LD_START = 1'b0; LD_VALID = 1'b0; LD_DATA = 8'h00; LD_LAST = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        #1;
        n_checks++;
        if (bus.RSP_VALID !== 1'b0) begin
            n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", bus.RSP_VALID);
        end
        n_checks++;
        if (bus.RSP_DATA !== 8'h00) begin
            n_fail++; $display("FAIL rst_rsp_data: got %h want 00", bus.RSP_DATA);
        end
        n_checks++;
        if ({LD_READY, LD_DONE, CORE_HOLD, LD_COUNT} !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_ld_outs: got rdy=%b done=%b hold=%b cnt=%0d want all 0",
                     LD_READY, LD_DONE, CORE_HOLD, LD_COUNT);
        end
        tick();
    endtask

    task automatic test_read_after_reset();
        drive_req(1'b1, 1'b0, 4'd5, 8'h00);
        #1;
        n_checks++;
        if (bus.REQ_READY !== 1'b1) begin
            n_fail++; $display("FAIL rd0_req_ready: got %b want 1", bus.REQ_READY);
        end
        tick();
        drive_req(1'b0, 1'b0, 4'd0, 8'h00);
        n_checks++;
        if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 8'h00) begin
            n_fail++;
            $display("FAIL rd0_rsp: got v=%b d=%h want v=1 d=00", bus.RSP_VALID, bus.RSP_DATA);
        end
        tick();
        n_checks++;
        if (bus.RSP_VALID !== 1'b0) begin
            n_fail++; $display("FAIL rd0_drop: got %b want 0", bus.RSP_VALID);
        end
    endtask

    task automatic test_write_read();
        drive_req(1'b1, 1'b1, 4'd3, 8'h5A);
        tick();
        n_checks++;
        if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 8'h5A) begin
            n_fail++;
            $display("FAIL wr_echo: got v=%b d=%h want v=1 d=5a", bus.RSP_VALID, bus.RSP_DATA);
        end
        drive_req(1'b1, 1'b0, 4'd3, 8'h00);
        #1;
        n_checks++;
        if (bus.REQ_READY !== 1'b1) begin
            n_fail++; $display("FAIL b2b_req_ready: got %b want 1", bus.REQ_READY);
        end
        tick();
        drive_req(1'b0, 1'b0, 4'd0, 8'h00);
        n_checks++;
        if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 8'h5A) begin
            n_fail++;
            $display("FAIL raw_read: got v=%b d=%h want v=1 d=5a", bus.RSP_VALID, bus.RSP_DATA);
        end
        tick();
        n_checks++;
        if (bus.RSP_VALID !== 1'b0) begin
            n_fail++; $display("FAIL wr_rd_drop: got %b want 0", bus.RSP_VALID);
        end
    endtask

    task automatic test_backpressure();
        drive_req(1'b1, 1'b1, 4'd7, 8'hC1);
        tick();
        drive_req(1'b1, 1'b0, 4'd7, 8'h00);
        tick();
        // Read of 0xC1 now buffered; stall it with a second read pending.
        drive_req(1'b1, 1'b0, 4'd3, 8'h00);
        bus.RSP_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (bus.REQ_READY !== 1'b0) begin
                n_fail++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, bus.REQ_READY);
            end
            tick();
            n_checks++;
            if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 8'hC1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h want v=1 d=c1", i, bus.RSP_VALID,
                         bus.RSP_DATA);
            end
        end
        bus.RSP_READY = 1'b1;
        #1;
        n_checks++;
        if (bus.REQ_READY !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got %b want 1", bus.REQ_READY);
        end
        tick();
        drive_req(1'b0, 1'b0, 4'd0, 8'h00);
        n_checks++;
        if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 8'h5A) begin
            n_fail++;
            $display("FAIL bp_next: got v=%b d=%h want v=1 d=5a", bus.RSP_VALID, bus.RSP_DATA);
        end
        tick();
    endtask

    task automatic test_full_load();
        LD_START = 1'b1;
        #1;
        n_checks++;
        if (bus.REQ_READY !== 1'b0) begin
            n_fail++; $display("FAIL ld_blocks_req: got %b want 0", bus.REQ_READY);
        end
        tick();
        LD_START = 1'b0;
        n_checks++;
        if (LD_READY !== 1'b1 || CORE_HOLD !== 1'b1 || LD_COUNT !== 5'd0) begin
            n_fail++;
            $display("FAIL ld_enter: got rdy=%b hold=%b cnt=%0d want 1 1 0", LD_READY, CORE_HOLD,
                     LD_COUNT);
        end
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 1) begin
                LD_VALID = 1'b0;
                tick();
                n_checks++;
                if (CORE_HOLD !== 1'b1 || LD_COUNT !== 5'(i)) begin
                    n_fail++;
                    $display("FAIL ld_gap[%0d]: got hold=%b cnt=%0d want 1 %0d", i, CORE_HOLD,
                             LD_COUNT, i);
                end
            end
            LD_VALID = 1'b1;
            LD_DATA  = 8'h40 + 8'(i);
            tick();
            n_checks++;
            if (LD_DONE !== (i == 15) || LD_COUNT !== 5'(i + 1) || CORE_HOLD !== 1'b1) begin
                n_fail++;
                $display("FAIL ld_byte[%0d]: got done=%b cnt=%0d hold=%b want %b %0d 1", i,
                         LD_DONE, LD_COUNT, CORE_HOLD, (i == 15), i + 1);
            end
        end
        LD_VALID = 1'b0;
        n_checks++;
        if (LD_READY !== 1'b0) begin
            n_fail++; $display("FAIL ld_done_rdy: got %b want 0", LD_READY);
        end
        tick();
        n_checks++;
        if (LD_DONE !== 1'b0 || CORE_HOLD !== 1'b0 || LD_COUNT !== 5'd16) begin
            n_fail++;
            $display("FAIL ld_exit: got done=%b hold=%b cnt=%0d want 0 0 16", LD_DONE, CORE_HOLD,
                     LD_COUNT);
        end
        drive_req(1'b1, 1'b0, 4'd0, 8'h00);
        tick();
        n_checks++;
        if (bus.RSP_DATA !== 8'h40) begin
            n_fail++; $display("FAIL ld_rd0: got %h want 40", bus.RSP_DATA);
        end
        drive_req(1'b1, 1'b0, 4'd15, 8'h00);
        tick();
        drive_req(1'b0, 1'b0, 4'd0, 8'h00);
        n_checks++;
        if (bus.RSP_DATA !== 8'h4F) begin
            n_fail++; $display("FAIL ld_rd15: got %h want 4f", bus.RSP_DATA);
        end
        tick();
    endtask

    task automatic test_short_load();
        // Leave a response pending, then request a load.
        drive_req(1'b1, 1'b0, 4'd4, 8'h00);
        tick();
        drive_req(1'b0, 1'b0, 4'd0, 8'h00);
        bus.RSP_READY = 1'b0;
        LD_START = 1'b1;
        tick(); tick();
        n_checks++;
        if (CORE_HOLD !== 1'b0 || bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 8'h44) begin
            n_fail++;
            $display("FAIL sl_wait: got hold=%b v=%b d=%h want 0 1 44", CORE_HOLD,
                     bus.RSP_VALID, bus.RSP_DATA);
        end
        bus.RSP_READY = 1'b1;
        tick();
        n_checks++;
        if (CORE_HOLD !== 1'b0 || bus.RSP_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL sl_drain: got hold=%b v=%b want 0 0", CORE_HOLD, bus.RSP_VALID);
        end
        tick();
        LD_START = 1'b0;
        n_checks++;
        if (CORE_HOLD !== 1'b1 || LD_COUNT !== 5'd0) begin
            n_fail++;
            $display("FAIL sl_enter: got hold=%b cnt=%0d want 1 0", CORE_HOLD, LD_COUNT);
        end
        for (int i = 0; i < 4; i++) begin
            LD_VALID = 1'b1;
            LD_DATA  = 8'hA0 + 8'(i);
            LD_LAST  = (i == 3);
            tick();
        end
        LD_VALID = 1'b0;
        LD_LAST  = 1'b0;
        n_checks++;
        if (LD_DONE !== 1'b1 || LD_COUNT !== 5'd4) begin
            n_fail++;
            $display("FAIL sl_done: got done=%b cnt=%0d want 1 4", LD_DONE, LD_COUNT);
        end
        tick();
        drive_req(1'b1, 1'b0, 4'd3, 8'h00);
        tick();
        n_checks++;
        if (bus.RSP_DATA !== 8'hA3) begin
            n_fail++; $display("FAIL sl_rd3: got %h want a3", bus.RSP_DATA);
        end
        drive_req(1'b1, 1'b0, 4'd4, 8'h00);
        tick();
        drive_req(1'b0, 1'b0, 4'd0, 8'h00);
        n_checks++;
        if (bus.RSP_DATA !== 8'h44 || LD_COUNT !== 5'd4) begin
            n_fail++;
            $display("FAIL sl_rd4: got d=%h cnt=%0d want 44 4", bus.RSP_DATA, LD_COUNT);
        end
        tick();
    endtask

    task automatic test_reset_mid_load();
        LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
        for (int i = 0; i < 7; i++) begin
            LD_VALID = 1'b1;
            LD_DATA  = 8'h11 + 8'(i);
            tick();
        end
        LD_VALID = 1'b0;
        n_checks++;
        if (CORE_HOLD !== 1'b1 || LD_COUNT !== 5'd7) begin
            n_fail++;
            $display("FAIL rml_pre: got hold=%b cnt=%0d want 1 7", CORE_HOLD, LD_COUNT);
        end
        RESET = 1'b1;
        #2;
        n_checks++;
        if (CORE_HOLD !== 1'b0 || LD_READY !== 1'b0 || LD_COUNT !== 5'd0) begin
            n_fail++;
            $display("FAIL rml_async: got hold=%b rdy=%b cnt=%0d want 0 0 0", CORE_HOLD,
                     LD_READY, LD_COUNT);
        end
        RESET = 1'b0;
        drive_req(1'b1, 1'b0, 4'd2, 8'h00);
        #1;
        n_checks++;
        if (bus.REQ_READY !== 1'b1) begin
            n_fail++; $display("FAIL rml_serve: got %b want 1", bus.REQ_READY);
        end
        tick();
        drive_req(1'b0, 1'b0, 4'd0, 8'h00);
        n_checks++;
        if (bus.RSP_VALID !== 1'b1 || bus.RSP_DATA !== 8'h00) begin
            n_fail++;
            $display("FAIL rml_rd2: got v=%b d=%h want 1 00", bus.RSP_VALID, bus.RSP_DATA);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_backpressure();
        test_full_load();
        test_short_load();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
